// File: rtl/set_assoc_wb_cache_pkg.sv
// Shared types for the set-associative write-back cache.
// Controller states plus a width helper that never yields zero.
package set_assoc_wb_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_WB_WAIT,
    S_ALLOCATE,
    S_FILL_WAIT
  } state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/set_assoc_wb_cache_lru_tracker.sv
// True-LRU age tracker: per-set age permutation, touch port,
// and the oldest way of the looked-up set.
module lru_tracker
  import set_assoc_wb_cache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 4,
  localparam int SW = clog2_min1(NUM_SETS),
  localparam int WW = clog2_min1(NUM_WAYS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          touch_i,
  input  logic [SW-1:0] touch_set_i,
  input  logic [WW-1:0] touch_way_i,
  input  logic [SW-1:0] set_i,
  output logic [WW-1:0] lru_way_o
);

  logic [WW-1:0] age_q [NUM_SETS][NUM_WAYS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WW'(w);
    end else if (touch_i) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WW'(w) == touch_way_i)
          age_q[touch_set_i][w] <= '0;
        else if (age_q[touch_set_i][w] <
                 age_q[touch_set_i][touch_way_i])
          age_q[touch_set_i][w] <= age_q[touch_set_i][w] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_way_o = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (age_q[set_i][w] == WW'(NUM_WAYS - 1))
        lru_way_o = WW'(w);
  end

endmodule

// File: rtl/set_assoc_wb_cache.sv
// N-way set-associative write-back, write-allocate data cache
// with one outstanding request and a line-wide memory port.
module set_assoc_wb_cache
  import set_assoc_wb_cache_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int NUM_SETS  = 4,
  parameter int NUM_WAYS  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         is_input_valid,
  input  logic [31:0]                  addr,
  input  logic                         mem_rw,
  input  logic [31:0]                  din,
  output logic                         is_ready,
  output logic                         is_output_valid,
  output logic [31:0]                  dout,
  output logic                         is_hit,
  output logic                         mem_is_input_valid,
  output logic [31-$clog2(LINE_SIZE):0] mem_addr,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [LINE_SIZE*8-1:0]       mem_din,
  input  logic                         mem_is_output_valid,
  input  logic [LINE_SIZE*8-1:0]       mem_dout,
  input  logic                         mem_ready,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
);

  localparam int OFF_W  = $clog2(LINE_SIZE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LA_W   = 32 - OFF_W;
  localparam int LINE_W = LINE_SIZE * 8;
  localparam int WSEL_W = clog2_min1(LINE_SIZE / 4);
  localparam int SW     = clog2_min1(NUM_SETS);
  localparam int WW     = clog2_min1(NUM_WAYS);

  state_t            state_q;
  logic [31:0]       req_addr_q;
  logic              req_rw_q;
  logic [31:0]       req_din_q;
  logic              missed_q;
  logic [WW-1:0]     victim_q;
  logic [31:0]       hit_cnt_q;
  logic [31:0]       miss_cnt_q;

  logic              valid_q [NUM_SETS][NUM_WAYS];
  logic              dirty_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic [LA_W-1:0]   req_line;
  logic [SW-1:0]     req_set;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_wsel;

  assign req_line = req_addr_q[31:OFF_W];
  assign req_set  = SW'(req_line & LA_W'(NUM_SETS - 1));
  assign req_tag  = TAG_W'(req_line >> IDX_W);
  assign req_wsel = WSEL_W'(req_addr_q[OFF_W-1:0] >> 2);

  logic          hit;
  logic [WW-1:0] hit_way;
  logic          has_inv;
  logic [WW-1:0] inv_way;
  logic [WW-1:0] lru_way;
  logic [WW-1:0] victim_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[req_set][w]) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  assign victim_way = has_inv ? inv_way : lru_way;

  lru_tracker #(
    .NUM_SETS(NUM_SETS),
    .NUM_WAYS(NUM_WAYS)
  ) u_lru (
    .clk        (clk),
    .reset      (reset),
    .touch_i    (state_q == S_COMPARE && hit),
    .touch_set_i(req_set),
    .touch_way_i(hit_way),
    .set_i      (req_set),
    .lru_way_o  (lru_way)
  );

  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] vic_line;
  logic [LA_W-1:0]   wb_addr;
  logic              wb_go;
  logic              rd_go;

  assign hit_line = data_q[req_set][hit_way];
  assign vic_line = data_q[req_set][victim_q];
  assign wb_addr  = (LA_W'(tag_q[req_set][victim_q]) << IDX_W)
                  | LA_W'(req_set);
  assign wb_go    = state_q == S_WRITEBACK && mem_ready;
  assign rd_go    = state_q == S_ALLOCATE && mem_ready;

  assign is_ready           = state_q == S_IDLE;
  assign is_output_valid    = state_q == S_COMPARE && hit;
  assign is_hit             = is_output_valid && !missed_q;
  assign dout               = (is_output_valid && !req_rw_q)
                            ? hit_line[{req_wsel, 5'b0} +: 32] : '0;
  assign mem_is_input_valid = wb_go || rd_go;
  assign mem_write          = wb_go;
  assign mem_read           = rd_go;
  assign mem_addr           = wb_go ? wb_addr : rd_go ? req_line : '0;
  assign mem_din            = wb_go ? vic_line : '0;
  assign hit_count          = hit_cnt_q;
  assign miss_count         = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      req_rw_q   <= 1'b0;
      req_din_q  <= '0;
      missed_q   <= 1'b0;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
    end else begin
      unique case (state_q)
        S_IDLE: if (is_input_valid) begin
          req_addr_q <= addr;
          req_rw_q   <= mem_rw;
          req_din_q  <= din;
          missed_q   <= 1'b0;
          state_q    <= S_COMPARE;
        end
        S_COMPARE: if (hit) begin
          if (req_rw_q) begin
            data_q[req_set][hit_way][{req_wsel, 5'b0} +: 32] <= req_din_q;
            dirty_q[req_set][hit_way] <= 1'b1;
          end
          if (!missed_q && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 1'b1;
          state_q <= S_IDLE;
        end else begin
          if (miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 1'b1;
          missed_q <= 1'b1;
          victim_q <= victim_way;
          state_q  <= (valid_q[req_set][victim_way] &&
                       dirty_q[req_set][victim_way])
                    ? S_WRITEBACK : S_ALLOCATE;
        end
        S_WRITEBACK: if (mem_ready) state_q <= S_WB_WAIT;
        S_WB_WAIT: if (mem_ready) begin
          dirty_q[req_set][victim_q] <= 1'b0;
          state_q <= S_ALLOCATE;
        end
        S_ALLOCATE: if (mem_ready) state_q <= S_FILL_WAIT;
        S_FILL_WAIT: if (mem_is_output_valid) begin
          valid_q[req_set][victim_q] <= 1'b1;
          dirty_q[req_set][victim_q] <= 1'b0;
          tag_q[req_set][victim_q]   <= req_tag;
          data_q[req_set][victim_q]  <= mem_dout;
          state_q <= S_COMPARE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
